// File: rtl/enc_event_fifo.sv
// Event-capture FIFO behind the 4-to-2 encoder: records each new {V,Y} event into a show-ahead FIFO.
// Optional per-entry timestamps are built when ENC_FIFO_TS_EN is defined.
module enc_event_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int TS_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enc_v,
    input  logic [1:0]        enc_y,
    input  logic              clr_ovf,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [1:0]        out_code,
    output logic [ADDR_W:0]   level,
    output logic              overflow
`ifdef ENC_FIFO_TS_EN
    ,
    output logic [TS_W-1:0]   out_ts
`endif
);

    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = (ADDR_W)'(1);

    if (DEPTH < 2 || (1 << ADDR_W) != DEPTH || TS_W < 1) begin : g_bad_param
        $error("enc_event_fifo: DEPTH must be a power of two >= 2 equal to 2**ADDR_W, TS_W >= 1");
    end

    logic [1:0]        mem_code [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              prev_v;
    logic [1:0]        prev_y;
    logic              enc_event;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;

    assign enc_event = enc_v & (~prev_v | (enc_y != prev_y));
    assign full      = (level == LVL_FULL);
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    assign push      = enc_event & (~full | pop);
    assign drop      = enc_event & full & ~pop;
    assign out_code  = out_valid ? mem_code[rd_ptr] : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_v   <= 1'b0;
            prev_y   <= 2'b00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            // dropped events still advance the history so a held code is not retried
            prev_v <= enc_v;
            prev_y <= enc_y;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_code[wr_ptr] <= enc_y;
    end

`ifdef ENC_FIFO_TS_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] mem_ts [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_cnt <= '0;
        else        ts_cnt <= ts_cnt + (TS_W)'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem_ts[wr_ptr] <= ts_cnt;
    end

    assign out_ts = out_valid ? mem_ts[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_enc_event_fifo.sv
// Self-checking bench for enc_event_fifo: vector table plus queue scoreboard, with async-reset
// and (when ENC_FIFO_TS_EN is defined) timestamp sequences.
module tb_enc_event_fifo;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int TS_W   = 8;

    logic              clk;
    logic              rst_n;
    logic              enc_v;
    logic [1:0]        enc_y;
    logic              clr_ovf;
    logic              out_ready;
    logic              out_valid;
    logic [1:0]        out_code;
    logic [ADDR_W:0]   level;
    logic              overflow;
`ifdef ENC_FIFO_TS_EN
    logic [TS_W-1:0]   out_ts;
`endif

    enc_event_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TS_W(TS_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enc_v     (enc_v),
        .enc_y     (enc_y),
        .clr_ovf   (clr_ovf),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .level     (level),
        .overflow  (overflow)
`ifdef ENC_FIFO_TS_EN
        ,
        .out_ts    (out_ts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] y;
        logic       rdy;
        logic       clr;
        int         exp_level;
        logic       exp_ovf;
        string      tag;
    } vec_t;

    vec_t       vecs[$];
    logic [1:0] sb[$];
    logic       m_pv;
    logic [1:0] m_py;
    logic       m_ovf;
    int         n_checks = 0;
    int         n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_pv  = 1'b0;
        m_py  = 2'b00;
        m_ovf = 1'b0;
    endtask

    task automatic add(input logic v, input logic [1:0] y, input logic rdy, input logic clr,
                       input int lvl, input logic ovf, input string tag);
        vec_t e;
        e.v = v; e.y = y; e.rdy = rdy; e.clr = clr;
        e.exp_level = lvl; e.exp_ovf = ovf; e.tag = tag;
        vecs.push_back(e);
    endtask

    // drive one cycle, advance the scoreboard model, compare after the edge
    task automatic cycle(input logic v, input logic [1:0] y, input logic rdy, input logic clr,
                         input string tag);
        logic ev, pp, ps, dr, fl;
        enc_v = v; enc_y = y; out_ready = rdy; clr_ovf = clr;
        ev = v & (~m_pv | (y != m_py));
        fl = (sb.size() == DEPTH);
        pp = (sb.size() != 0) & rdy;
        ps = ev & (~fl | pp);
        dr = ev & fl & ~pp;
        @(posedge clk);
        #1;
        if (pp) void'(sb.pop_front());
        if (ps) sb.push_back(y);
        if (dr)       m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_pv = v;
        m_py = y;
        chk({tag, " level"},     level,     sb.size());
        chk({tag, " out_valid"}, out_valid, (sb.size() != 0));
        chk({tag, " overflow"},  overflow,  m_ovf);
        if (sb.size() != 0) chk({tag, " out_code"}, out_code, sb[0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enc_v = 1'b0; enc_y = 2'b00; clr_ovf = 1'b0; out_ready = 1'b0;
        model_reset();

        // reset with random inputs
        repeat (3) begin
            @(posedge clk);
            #1;
            enc_v = 1'($urandom); enc_y = 2'($urandom);
            clr_ovf = 1'($urandom); out_ready = 1'($urandom);
        end
        chk("reset out_valid", out_valid, 0);
        chk("reset level",     level,     0);
        chk("reset overflow",  overflow,  0);
        chk("reset out_code",  out_code,  0);
        rst_n = 1'b1;

        // single held event
        add(1, 2'd2, 0, 0, 1, 0, "single0");
        for (int i = 1; i < 5; i++) add(1, 2'd2, 0, 0, 1, 0, "single_hold");
        add(0, 2'd0, 1, 0, 0, 0, "single_drain");
        // code changes while V held
        add(1, 2'd0, 0, 0, 1, 0, "chg0");
        add(1, 2'd1, 0, 0, 2, 0, "chg1");
        add(1, 2'd3, 0, 0, 3, 0, "chg3");
        add(1, 2'd3, 0, 0, 3, 0, "chg3_hold");
        add(1, 2'd2, 0, 0, 4, 0, "chg2");
        add(0, 2'd0, 1, 0, 3, 0, "chg_drain1");
        add(0, 2'd0, 1, 0, 2, 0, "chg_drain2");
        add(0, 2'd0, 1, 0, 1, 0, "chg_drain3");
        add(0, 2'd0, 1, 0, 0, 0, "chg_drain4");
        add(0, 2'd0, 1, 0, 0, 0, "ready_empty");
        // overflow, clear, full+pop, clear vs drop
        add(1, 2'd0, 0, 0, 1, 0, "ovf_e1");
        add(1, 2'd1, 0, 0, 2, 0, "ovf_e2");
        add(1, 2'd2, 0, 0, 3, 0, "ovf_e3");
        add(1, 2'd3, 0, 0, 4, 0, "ovf_e4");
        add(1, 2'd0, 0, 0, 4, 1, "ovf_drop");
        add(1, 2'd0, 0, 1, 4, 0, "ovf_clr");
        add(1, 2'd1, 1, 0, 4, 0, "full_pop");
        add(1, 2'd2, 0, 1, 4, 1, "clr_vs_drop");
        add(1, 2'd2, 0, 1, 4, 0, "clr_again");
        add(0, 2'd0, 1, 0, 3, 0, "tail_drain1");
        add(0, 2'd0, 1, 0, 2, 0, "tail_drain2");
        add(0, 2'd0, 1, 0, 1, 0, "tail_drain3");
        add(0, 2'd0, 1, 0, 0, 0, "tail_drain4");
        add(1, 2'd2, 1, 0, 1, 0, "empty_no_bypass");

        foreach (vecs[i]) begin
            cycle(vecs[i].v, vecs[i].y, vecs[i].rdy, vecs[i].clr, vecs[i].tag);
            chk({vecs[i].tag, " tbl_level"}, level,    vecs[i].exp_level);
            chk({vecs[i].tag, " tbl_ovf"},   overflow, vecs[i].exp_ovf);
        end
        chk("full_pop tail order", out_code, 2);

        // async reset mid-stream with level 3
        cycle(1, 2'd0, 0, 0, "pre_rst1");
        cycle(1, 2'd1, 0, 0, "pre_rst2");
        chk("pre_rst level", level, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst out_valid", out_valid, 0);
        chk("async_rst level",     level,     0);
        chk("async_rst overflow",  overflow,  0);
        chk("async_rst out_code",  out_code,  0);
        model_reset();
        @(posedge clk);
        #1;
        enc_v = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        rst_n = 1'b1;

`ifdef ENC_FIFO_TS_EN
        begin
            logic [TS_W-1:0] ts_a;
            logic [TS_W-1:0] ts_b;
            cycle(1, 2'd1, 0, 0, "ts_ev_a");
            ts_a = out_ts;
            cycle(1, 2'd1, 0, 0, "ts_hold1");
            cycle(1, 2'd1, 0, 0, "ts_hold2");
            cycle(1, 2'd2, 0, 0, "ts_ev_b");
            cycle(0, 2'd0, 1, 0, "ts_pop_a");
            ts_b = out_ts;
            chk("ts delta", ts_b - ts_a, 3);
            cycle(0, 2'd0, 1, 0, "ts_pop_b");
        end
`endif

        cycle(1, 2'd3, 0, 0, "post_rst_event");
        chk("post_rst code", out_code, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/enc_event_fifo.md
Name: enc_event_fifo

Overview:
- Downstream stage of the 4-to-2 priority/one-hot encoder; consumes its {V,Y} output.
- Registers the encoded code on each new valid event: V rising, or Y changing while V stays high.
- Buffers captured events in a small show-ahead FIFO with a valid/ready read port.
- Flags overflow when events arrive faster than the consumer drains them.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
ADDR_W, 2, log2(DEPTH); must match DEPTH
TS_W, 8, timestamp width; used only with ENC_FIFO_TS_EN

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
enc_v  input  1  valid from encoder (V)
enc_y  input  2  code from encoder (Y)
clr_ovf  input  1  synchronous clear of overflow flag
out_ready  input  1  consumer accepts head entry
out_valid  output  1  FIFO non-empty
out_code  output  2  head entry code
level  output  ADDR_W+1  current entry count, 0..DEPTH
overflow  output  1  sticky: an event was dropped
out_ts  output  TS_W  head entry timestamp (ENC_FIFO_TS_EN only)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Asserting rst_n=0 immediately clears all of: rd/wr pointers, level, prev_v, prev_y, overflow, timestamp counter.
  - Immediately after reset: out_valid=0, out_code=0, level=0, overflow=0, out_ts=0.
  - Reset mid-operation discards all stored entries. Memory contents need not be cleared.
- Event detect:
  - prev_v/prev_y register enc_v/enc_y every cycle.
  - event = enc_v & (~prev_v | (enc_y != prev_y)).
  - enc_v held high with a stable code produces exactly one event.
  - enc_v=0 produces no event.
- Push: push = event & (~full | pop).
  - Writes enc_y at wr_ptr; wr_ptr increments modulo DEPTH, wrapping naturally.
- Pop: pop = out_valid & out_ready.
  - rd_ptr increments modulo DEPTH.
  - out_ready while empty has no effect.
- Latency: an event sampled at edge N is visible on out_code with out_valid=1 after edge N. There is no combinational path from enc_v/enc_y to outputs.
- Show-ahead: out_code = mem[rd_ptr] while out_valid=1; value is don't-care while empty.
- level:
  - +1 on push only; -1 on pop only; unchanged on both or neither.
  - full = (level==DEPTH); empty = (level==0).
- Full plus event:
  - Without pop: event dropped and overflow set to 1 at that edge; FIFO unchanged.
  - With pop in the same cycle: event accepted, level stays DEPTH, no overflow.
- Empty plus event plus out_ready: no bypass. The entry is pushed; the pop is ignored because out_valid=0.
- overflow:
  - Stays set until clr_ovf=1 at a clock edge.
  - If clr_ovf and a drop occur in the same cycle, set wins and overflow stays 1.
- Dropped events still update prev_v/prev_y, so the same held code is not retried.

Optional Feature:
- Macro: ENC_FIFO_TS_EN.
- Defined:
  - A free-running TS_W-bit counter increments every cycle from 0 after reset and wraps at 2^TS_W-1 to 0.
  - Each pushed entry stores the counter value at the push edge.
  - out_ts presents the head entry's timestamp, show-ahead like out_code.
- Undefined: no counter, no timestamp storage, out_ts port absent.

Test Plan:
- Reset state: hold rst_n=0 with random inputs, then release -> out_valid=0, level=0, overflow=0, out_code=0.
- Single event: enc_v=1, enc_y=2'b10 held 5 cycles, out_ready=0 -> level=1 after the first edge and stays 1; out_code=2'b10.
- Code-change events: enc_v held 1 while enc_y goes 0,1,3,3,2 on consecutive cycles -> 4 entries (0,1,3,2); drained with out_ready=1 in that order, then out_valid=0.
- Overflow: DEPTH=4, 5 distinct events, out_ready=0 -> level=4, overflow=1, the 5th code absent. Pulse clr_ovf -> overflow=0 with entries kept.
- Full plus simultaneous pop: FIFO full, new event with out_ready=1 -> level stays 4, overflow=0, new code at tail, oldest code removed.
- Async reset mid-stream: rst_n low between edges with level=3 -> outputs clear at once, without waiting for clk. With ENC_FIFO_TS_EN, check events 3 cycles apart after reset carry out_ts values differing by 3.
